// File: rtl/qbus_slave_seq.sv
// qbus_slave_seq: Q-bus slave cycle sequencer.
// Handles the address phase, DATI/DATO/DATIO data phases with a programmable
// RPLY delay, and interrupt-acknowledge vector or daisy-chain pass-through.
// All bus inputs arrive already synchronized to qclk; all outputs are registered.
module qbus_slave_seq #(
    parameter int unsigned RPLY_DLY = 2
) (
    input  logic        qclk,
    input  logic        reset,
    input  logic        RSYNC,
    input  logic        RDIN,
    input  logic        RDOUT,
    input  logic        RIAKI,
    input  logic        RBS7_in,
    input  logic [15:0] RDAL,
    output logic [12:0] RAL,
    output logic        RBS7,
    output logic [15:0] RDL,
    input  logic [15:0] TDL,
    input  logic        addr_match,
    input  logic        vec_request,
    output logic        write_pulse,
    output logic        assert_vector,
    output logic [15:0] TDAL,
    output logic        TDAL_en,
    output logic        TRPLY,
    output logic        TIAKO
);

    typedef enum logic [3:0] {
        IDLE,
        ADDR,
        DIN_DLY,
        DIN_RPLY,
        DOUT_WR,
        DOUT_DLY,
        DOUT_RPLY,
        IAK_DLY,
        IAK_RPLY,
        IAK_PASS
    } state_t;

    localparam logic [3:0] DLY_LOAD = 4'(RPLY_DLY);

    state_t     state;
    logic [3:0] dly_cnt;
    logic       rsync_q;
    logic       sync_abort;

    // SYNC dropping while inside an address/data cycle abandons that cycle
    assign sync_abort = !RSYNC &&
                        (state inside {ADDR, DIN_DLY, DIN_RPLY, DOUT_WR,
                                       DOUT_DLY, DOUT_RPLY});

    // Bus cycle sequencer; every output is a register updated here
    always_ff @(posedge qclk) begin
        if (reset) begin
            state         <= IDLE;
            dly_cnt       <= 4'd0;
            rsync_q       <= 1'b1;
            RAL           <= 13'd0;
            RBS7          <= 1'b0;
            RDL           <= 16'd0;
            write_pulse   <= 1'b0;
            assert_vector <= 1'b0;
            TDAL          <= 16'd0;
            TDAL_en       <= 1'b0;
            TRPLY         <= 1'b0;
            TIAKO         <= 1'b0;
        end else begin
            rsync_q     <= RSYNC;
            write_pulse <= 1'b0;
            if (sync_abort) begin
                state   <= IDLE;
                dly_cnt <= 4'd0;
                TDAL    <= 16'd0;
                TDAL_en <= 1'b0;
                TRPLY   <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (RSYNC && !rsync_q) begin
                            RAL   <= RDAL[12:0];
                            RBS7  <= RBS7_in;
                            state <= ADDR;
                        end else if (!RSYNC && RDIN && RIAKI) begin
                            if (vec_request) begin
                                assert_vector <= 1'b1;
                                TDAL_en       <= 1'b1;
                                TDAL          <= TDL;
                                dly_cnt       <= DLY_LOAD;
                                state         <= IAK_DLY;
                            end else begin
                                TIAKO <= 1'b1;
                                state <= IAK_PASS;
                            end
                        end
                    end
                    ADDR: begin
                        if (addr_match && RDIN) begin
                            TDAL    <= TDL;
                            TDAL_en <= 1'b1;
                            dly_cnt <= DLY_LOAD;
                            state   <= DIN_DLY;
                        end else if (addr_match && RDOUT) begin
                            RDL         <= RDAL;
                            write_pulse <= 1'b1;
                            state       <= DOUT_WR;
                        end
                    end
                    DIN_DLY: begin
                        TDAL <= TDL;
                        if (dly_cnt <= 4'd1) begin
                            dly_cnt <= 4'd0;
                            TRPLY   <= 1'b1;
                            state   <= DIN_RPLY;
                        end else begin
                            dly_cnt <= dly_cnt - 4'd1;
                        end
                    end
                    DIN_RPLY: begin
                        if (!RDIN) begin
                            TRPLY   <= 1'b0;
                            TDAL_en <= 1'b0;
                            TDAL    <= 16'd0;
                            state   <= ADDR;
                        end
                    end
                    DOUT_WR: begin
                        dly_cnt <= DLY_LOAD;
                        state   <= DOUT_DLY;
                    end
                    DOUT_DLY: begin
                        if (dly_cnt <= 4'd1) begin
                            dly_cnt <= 4'd0;
                            TRPLY   <= 1'b1;
                            state   <= DOUT_RPLY;
                        end else begin
                            dly_cnt <= dly_cnt - 4'd1;
                        end
                    end
                    DOUT_RPLY: begin
                        if (!RDOUT) begin
                            TRPLY <= 1'b0;
                            state <= ADDR;
                        end
                    end
                    IAK_DLY: begin
                        if (!RDIN || !RIAKI) begin
                            assert_vector <= 1'b0;
                            TDAL_en       <= 1'b0;
                            TDAL          <= 16'd0;
                            dly_cnt       <= 4'd0;
                            state         <= IDLE;
                        end else begin
                            TDAL <= TDL;
                            if (dly_cnt <= 4'd1) begin
                                dly_cnt <= 4'd0;
                                TRPLY   <= 1'b1;
                                state   <= IAK_RPLY;
                            end else begin
                                dly_cnt <= dly_cnt - 4'd1;
                            end
                        end
                    end
                    IAK_RPLY, IAK_PASS: begin
                        if (!RDIN || !RIAKI) begin
                            assert_vector <= 1'b0;
                            TDAL_en       <= 1'b0;
                            TDAL          <= 16'd0;
                            TRPLY         <= 1'b0;
                            TIAKO         <= 1'b0;
                            state         <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qbus_slave_seq.sv
// tb_qbus_slave_seq: directed bench for qbus_slave_seq with a queue of
// expected values pushed as each step is driven and popped as outputs appear.
module tb_qbus_slave_seq;

    logic        qclk = 1'b0;
    logic        reset;
    logic        RSYNC;
    logic        RDIN;
    logic        RDOUT;
    logic        RIAKI;
    logic        RBS7_in;
    logic [15:0] RDAL;
    logic [12:0] RAL;
    logic        RBS7;
    logic [15:0] RDL;
    logic [15:0] TDL;
    logic        addr_match;
    logic        vec_request;
    logic        write_pulse;
    logic        assert_vector;
    logic [15:0] TDAL;
    logic        TDAL_en;
    logic        TRPLY;
    logic        TIAKO;

    int          checks = 0;
    int          errors = 0;
    int          wp_count = 0;
    int          wp_base = 0;
    logic [31:0] sb[$];

    qbus_slave_seq #(.RPLY_DLY(2)) dut (
        .qclk          (qclk),
        .reset         (reset),
        .RSYNC         (RSYNC),
        .RDIN          (RDIN),
        .RDOUT         (RDOUT),
        .RIAKI         (RIAKI),
        .RBS7_in       (RBS7_in),
        .RDAL          (RDAL),
        .RAL           (RAL),
        .RBS7          (RBS7),
        .RDL           (RDL),
        .TDL           (TDL),
        .addr_match    (addr_match),
        .vec_request   (vec_request),
        .write_pulse   (write_pulse),
        .assert_vector (assert_vector),
        .TDAL          (TDAL),
        .TDAL_en       (TDAL_en),
        .TRPLY         (TRPLY),
        .TIAKO         (TIAKO)
    );

    // 20 MHz qclk
    always #25 qclk = ~qclk;

    // Count cycles in which the write strobe is high
    always @(posedge qclk) begin
        if (write_pulse === 1'b1) wp_count++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge qclk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic sync, input logic din,
                                 input logic dout, input logic iaki);
        RSYNC = sync;
        RDIN  = din;
        RDOUT = dout;
        RIAKI = iaki;
    endtask

    task automatic pushExpected(input logic [31:0] value);
        sb.push_back(value);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed);
        logic [31:0] expected;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s: observed %0h but no expected value queued", tag, observed);
        end else begin
            expected = sb.pop_front();
            assert (observed === expected) else begin
                errors++;
                $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
            end
        end
    endtask

    initial begin
        // Reset with bus inputs active; SYNC held high across release
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        RBS7_in = 1'b1; RDAL = 16'o017570; TDL = 16'o000777;
        addr_match = 1'b1; vec_request = 1'b0;
        tick(2);
        pushExpected(0); pushExpected(0); pushExpected(0); pushExpected(0); pushExpected(0);
        checkOutput("rst_trply", TRPLY);
        checkOutput("rst_tdal_en", TDAL_en);
        checkOutput("rst_tdal", TDAL);
        checkOutput("rst_ral", RAL);
        checkOutput("rst_wp", write_pulse);
        reset = 1'b0;
        tick(3);
        pushExpected(0); pushExpected(0); pushExpected(0);
        checkOutput("nosync_edge_ral", RAL);
        checkOutput("nosync_edge_tdal_en", TDAL_en);
        checkOutput("nosync_edge_trply", TRPLY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // DATI
        RDAL = 16'o017570; RBS7_in = 1'b1; TDL = 16'o000777; addr_match = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        pushExpected(32'o17570); pushExpected(1); pushExpected(0);
        checkOutput("dati_ral", RAL);
        checkOutput("dati_rbs7", RBS7);
        checkOutput("dati_addr_tdal_en", TDAL_en);
        RDAL = 16'd0;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(1);
        pushExpected(16'o000777); pushExpected(1); pushExpected(0);
        checkOutput("dati_tdal", TDAL);
        checkOutput("dati_tdal_en", TDAL_en);
        checkOutput("dati_trply_d0", TRPLY);
        tick(1);
        pushExpected(0);
        checkOutput("dati_trply_d1", TRPLY);
        tick(1);
        pushExpected(1); pushExpected(16'o000777);
        checkOutput("dati_trply", TRPLY);
        checkOutput("dati_tdal_held", TDAL);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        pushExpected(0); pushExpected(0);
        checkOutput("dati_trply_drop", TRPLY);
        checkOutput("dati_tdal_en_drop", TDAL_en);

        // DATO in the same SYNC (DATIO)
        wp_base = wp_count;
        RDAL = 16'o123456;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        pushExpected(16'o123456); pushExpected(1); pushExpected(0);
        checkOutput("dato_rdl", RDL);
        checkOutput("dato_wp", write_pulse);
        checkOutput("dato_trply_early", TRPLY);
        RDAL = 16'd0;
        tick(1);
        pushExpected(0); pushExpected(0);
        checkOutput("dato_wp_end", write_pulse);
        checkOutput("dato_trply_d0", TRPLY);
        tick(1);
        pushExpected(0);
        checkOutput("dato_trply_d1", TRPLY);
        tick(1);
        pushExpected(1);
        checkOutput("dato_trply", TRPLY);
        tick(1);
        pushExpected(1); pushExpected(0);
        checkOutput("dato_trply_hold", TRPLY);
        checkOutput("dato_wp_once", write_pulse);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        pushExpected(0); pushExpected(16'o123456);
        checkOutput("dato_trply_drop", TRPLY);
        checkOutput("dato_rdl_hold", RDL);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);
        pushExpected(1); pushExpected(0); pushExpected(32'o17570);
        checkOutput("datio_pulse_count", 32'(wp_count - wp_base));
        checkOutput("datio_idle_trply", TRPLY);
        checkOutput("datio_ral_hold", RAL);

        // No address match: nothing driven for DIN then DOUT
        addr_match = 1'b0; RDAL = 16'o160000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            pushExpected(0); pushExpected(0);
            checkOutput("nomatch_din_trply", TRPLY);
            checkOutput("nomatch_din_tdal_en", TDAL_en);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            pushExpected(0); pushExpected(0);
            checkOutput("nomatch_dout_wp", write_pulse);
            checkOutput("nomatch_dout_trply", TRPLY);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // DIN and DOUT together: read wins, then SYNC abort from DIN_RPLY
        addr_match = 1'b1; RDAL = 16'o017570;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        RDAL = 16'o000007;
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0);
        tick(1);
        pushExpected(1); pushExpected(0);
        checkOutput("both_tdal_en", TDAL_en);
        checkOutput("both_wp", write_pulse);
        tick(2);
        pushExpected(1); pushExpected(0); pushExpected(16'o123456);
        checkOutput("both_trply", TRPLY);
        checkOutput("both_wp_late", write_pulse);
        checkOutput("both_rdl_untouched", RDL);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1);
        pushExpected(0); pushExpected(0);
        checkOutput("abort_din_trply", TRPLY);
        checkOutput("abort_din_tdal_en", TDAL_en);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // IAK with vector
        addr_match = 1'b0; vec_request = 1'b1; TDL = 16'o000220;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        pushExpected(1); pushExpected(1); pushExpected(16'o000220);
        pushExpected(0); pushExpected(0);
        checkOutput("iak_assert_vector", assert_vector);
        checkOutput("iak_tdal_en", TDAL_en);
        checkOutput("iak_tdal", TDAL);
        checkOutput("iak_trply_early", TRPLY);
        checkOutput("iak_tiako", TIAKO);
        tick(1);
        pushExpected(0);
        checkOutput("iak_trply_d1", TRPLY);
        tick(1);
        pushExpected(1);
        checkOutput("iak_trply", TRPLY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1);
        pushExpected(0); pushExpected(0); pushExpected(0);
        checkOutput("iak_end_assert_vector", assert_vector);
        checkOutput("iak_end_tdal_en", TDAL_en);
        checkOutput("iak_end_trply", TRPLY);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // IAK pass-through
        vec_request = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick(1);
        pushExpected(1); pushExpected(0); pushExpected(0);
        checkOutput("pass_tiako", TIAKO);
        checkOutput("pass_assert_vector", assert_vector);
        checkOutput("pass_tdal_en", TDAL_en);
        tick(3);
        pushExpected(0); pushExpected(1);
        checkOutput("pass_trply", TRPLY);
        checkOutput("pass_tiako_hold", TIAKO);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick(1);
        pushExpected(0);
        checkOutput("pass_tiako_drop", TIAKO);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // SYNC abort in DOUT_DLY
        addr_match = 1'b1; RDAL = 16'o017570;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        RDAL = 16'o000055;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        tick(1);
        pushExpected(1); pushExpected(16'o000055);
        checkOutput("abort_dout_wp", write_pulse);
        checkOutput("abort_dout_rdl", RDL);
        tick(1);
        pushExpected(0);
        checkOutput("abort_dout_wp_end", write_pulse);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        tick(1);
        pushExpected(0);
        checkOutput("abort_dout_trply", TRPLY);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            pushExpected(0); pushExpected(0);
            checkOutput("abort_dout_trply_after", TRPLY);
            checkOutput("abort_dout_wp_after", write_pulse);
        end
        pushExpected(16'o000055);
        checkOutput("abort_dout_rdl_hold", RDL);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        // Reset during DIN_RPLY
        TDL = 16'o000777;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick(3);
        pushExpected(1); pushExpected(1);
        checkOutput("rstmid_trply_before", TRPLY);
        checkOutput("rstmid_tdal_en_before", TDAL_en);
        reset = 1'b1;
        tick(1);
        pushExpected(0); pushExpected(0); pushExpected(0); pushExpected(0);
        checkOutput("rstmid_trply", TRPLY);
        checkOutput("rstmid_tdal_en", TDAL_en);
        checkOutput("rstmid_ral", RAL);
        checkOutput("rstmid_rdl", RDL);
        reset = 1'b0;
        tick(2);
        pushExpected(0); pushExpected(0);
        checkOutput("rstmid_no_restart_trply", TRPLY);
        checkOutput("rstmid_no_restart_tdal_en", TDAL_en);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/qbus_slave_seq.md
QBUS_SLAVE_SEQ -- requirements
Module: qbus_slave_seq

Interface
REQ-001 Parameter: RPLY_DLY, 2, qclk cycles between data-strobe recognition (or write_pulse) and TRPLY assertion; legal range 1..15.
REQ-002 qclk  in  1  20 MHz system clock; the only clock.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge qclk.
REQ-004 RSYNC  in  1  bus SYNC, pre-synchronized to qclk, active-high.
REQ-005 RDIN  in  1  bus DIN, pre-synchronized, active-high.
REQ-006 RDOUT  in  1  bus DOUT, pre-synchronized, active-high.
REQ-007 RIAKI  in  1  interrupt-acknowledge daisy-chain input, pre-synchronized, active-high.
REQ-008 RBS7_in  in  1  bus BS7 as sampled during the address phase.
REQ-009 RDAL  in  16  bus DAL[15:0] receivers.
REQ-010 RAL  out  13  latched address DAL[12:0] presented to device registers.
REQ-011 RBS7  out  1  latched BS7 presented to device registers.
REQ-012 RDL  out  16  latched write data presented to device registers.
REQ-013 TDL  in  16  read data / vector from the selected device register.
REQ-014 addr_match  in  1  device claims the latched address (combinational from RAL/RBS7).
REQ-015 vec_request  in  1  device has an interrupt pending and owns this IAK slot.
REQ-016 write_pulse  out  1  one-cycle register write strobe.
REQ-017 assert_vector  out  1  device shall place its vector on TDL.
REQ-018 TDAL  out  16  data driven toward bus DAL transmitters.
REQ-019 TDAL_en  out  1  DAL transmitter enable.
REQ-020 TRPLY  out  1  bus RPLY, active-high.
REQ-021 TIAKO  out  1  IAK pass-through to next device, active-high.

Function
REQ-022 States: IDLE, ADDR, DIN_DLY, DIN_RPLY, DOUT_WR, DOUT_DLY, DOUT_RPLY, IAK_DLY, IAK_RPLY, IAK_PASS.
REQ-023 IDLE: RSYNC 0->1 (consecutive samples) SHALL latch RAL<=RDAL[12:0], RBS7<=RBS7_in same edge and enter ADDR; RSYNC already high out of reset is not an edge.
REQ-024 ADDR, addr_match=1, RDIN=1 -> DIN_DLY: TDAL<=TDL, TDAL_en=1 from the next edge, delay counter loaded with RPLY_DLY.
REQ-025 DIN_DLY: counter decrements each cycle; at zero TRPLY=1, enter DIN_RPLY; TDAL tracks TDL each cycle until TRPLY asserts, then held.
REQ-026 DIN_RPLY: RDIN 1->0 -> TRPLY=0 and TDAL_en=0 on the next edge, return ADDR (permits DATIO).
REQ-027 ADDR, addr_match=1, RDOUT=1 -> DOUT_WR: RDL<=RDAL on the recognition edge; write_pulse=1 for exactly the following cycle.
REQ-028 DOUT_WR -> DOUT_DLY (RPLY_DLY cycles) -> TRPLY=1, DOUT_RPLY; RDOUT 1->0 -> TRPLY=0 next edge, return ADDR.
REQ-029 ADDR, addr_match=0: no outputs driven; remain until RSYNC falls.
REQ-030 RDIN and RDOUT both high in ADDR: RDIN wins; write_pulse SHALL NOT fire.
REQ-031 IDLE, RSYNC=0, RDIN=1, RIAKI=1: vec_request=1 -> assert_vector=1, TDAL_en=1, TDAL<=TDL, IAK_DLY then TRPLY=1 in IAK_RPLY; vec_request=0 -> TIAKO=1 in IAK_PASS.
REQ-032 IAK_RPLY/IAK_PASS: RDIN or RIAKI low -> all IAK outputs 0 next edge, IDLE.
REQ-033 RSYNC 1->0 in any SYNC-based state: abort; next edge all outputs 0 (RAL/RBS7/RDL hold), IDLE.
REQ-034 write_pulse SHALL fire at most once per DOUT strobe; TRPLY never asserts in IDLE or ADDR.

Reset
REQ-035 reset SHALL force IDLE, counter 0, TRPLY=0, TDAL_en=0, TDAL=0, write_pulse=0, assert_vector=0, TIAKO=0, RAL=0, RBS7=0, RDL=0, overriding all bus inputs that cycle.
REQ-036 reset mid-cycle SHALL drop TRPLY and TDAL_en on the reset edge; a later RSYNC rise is required to restart.

Verification
REQ-037 DATI: RDAL=17570, RBS7_in=1, SYNC rise, match, DIN, TDL=0777 -> TDAL=0777, TDAL_en next edge, TRPLY 2 cycles later, both 0 one edge after DIN falls.
REQ-038 DATO: address 17570, DOUT with RDAL=123456 -> RDL=123456, write_pulse one cycle, TRPLY 2 cycles after pulse, drops one edge after DOUT falls.
REQ-039 No match: addr_match=0, DIN then DOUT -> TRPLY, TDAL_en, write_pulse stay 0 throughout.
REQ-040 IAK: vec_request=1, TDL=000220 -> assert_vector, TDAL=000220, TRPLY; repeat vec_request=0 -> TIAKO=1, TRPLY=0.
REQ-041 Abort: RSYNC falls in DOUT_DLY -> TRPLY never asserts, IDLE next edge; reset during DIN_RPLY -> TRPLY=0 same edge.
REQ-042 DATIO: DIN read then DOUT write in one SYNC -> one TRPLY per strobe, exactly one write_pulse.
